sram_mem_ctrl: RTL and testbench



---
 rtl/sram_mem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: splits each 32-bit MEM-stage load/store into two 16-bit
// accesses on an asynchronous SRAM and holds ready low until the word completes.
// Optional feature macro: SRAM_CTRL_RANGE_CHECK_EN (alignment/range rejection, err pulse).
module sram_mem_ctrl #(
    parameter int unsigned ADDR_W        = 18,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned BASE_ADDR     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_en,
    input  logic              write_en,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic              err,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned WRD_W = ADDR_W - 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WRD_W-1:0]   wrd_q, wrd_d;
    logic               wr_q, wr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        dqo_q, dqo_d;
    logic               dq_oe_q, dq_oe_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;
    logic               req;
    logic               bad;
    logic [31:0]        offs;
    logic [WRD_W-1:0]   wrd_in;

    assign req    = read_en | write_en;
    assign offs   = address - 32'(BASE_ADDR);
    assign wrd_in = WRD_W'(offs >> 2);
    assign ready  = ~req | (state_q == DONE);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + (33'(1) << (ADDR_W + 1));
    logic err_q, err_d;

    assign bad = (address[1:0] != 2'b00) || (address < 32'(BASE_ADDR)) ||
                 ({1'b0, address} >= LIMIT);

    // Rejected requests pulse err in the DONE cycle that follows.
    always_comb begin
        err_d = (state_q == IDLE) && req && bad;
    end

    // Error pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign bad = 1'b0;
    assign err = 1'b0;
`endif

    // State and counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wrd_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrd_q   <= wrd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic: IDLE -> LO -> HI -> DONE -> IDLE, each phase ACCESS_CYCLES long.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrd_d   = wrd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad) begin
                        state_d = DONE;
                    end else begin
                        state_d = LO;
                        cnt_d   = CNT_RELOAD;
                        wrd_d   = wrd_in;
                        wr_d    = write_en;
                        wdata_d = write_data;
                    end
                end
            end
            LO: begin
                if (cnt_q == '0) begin
                    state_d = HI;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HI: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: strobes are computed from the upcoming state so the
    // registered pins line up with the phase they belong to.
    always_comb begin
        addr_d  = addr_q;
        dqo_d   = dqo_q;
        dq_oe_d = 1'b0;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        rdata_d = rdata_q;
        if (state_d == LO || state_d == HI) begin
            addr_d = {wrd_d, state_d == HI};
            if (wr_d) begin
                dq_oe_d = 1'b1;
                dqo_d   = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
                we_n_d  = (cnt_d == '0);
            end else begin
                oe_n_d = 1'b0;
            end
        end
        if ((state_q == LO || state_q == HI) && !wr_q && cnt_q == '0) begin
            if (state_q == HI) rdata_d[31:16] = sram_dq_in;
            else               rdata_d[15:0]  = sram_dq_in;
        end
    end

    // Registered SRAM pins and load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            dqo_q   <= '0;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            dqo_q   <= dqo_d;
            dq_oe_q <= dq_oe_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            rdata_q <= rdata_d;
        end
    end

    assign sram_addr   = addr_q;
    assign sram_dq_out = dqo_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;
    assign read_data   = rdata_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: word-level reference memory, an asynchronous SRAM
// model on the pins, directed scenarios plus randomized load/store traffic.
module tb_sram_mem_ctrl;

    localparam int unsigned AC   = 2;
    localparam int unsigned BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en, write_en;
    logic [31:0] address, write_data, read_data;
    logic        ready, err;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] sram [0:4095];
    logic [31:0] ref_mem [0:2047];
    logic [31:0] last_rd;
    bit          sram_init = 1'b0;
    bit          pend = 1'b0;
    logic [17:0] paddr;
    logic [15:0] pdata;

    sram_mem_ctrl #(.ADDR_W(18), .ACCESS_CYCLES(AC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .err(err), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: reads while OE# is low, latches data when WE# rises.
    always_comb sram_dq_in = (sram_oe_n === 1'b0) ? sram[sram_addr[11:0]] : 16'h0000;

    always @(negedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 4096; i++) sram[i] = 16'h0000;
            sram_init = 1'b1;
        end
        if (sram_we_n === 1'b0) begin
            pend  = 1'b1;
            paddr = sram_addr;
            pdata = sram_dq_out;
        end else if (pend && sram_we_n === 1'b1) begin
            sram[paddr[11:0]] = pdata;
            pend = 1'b0;
        end
    end

    // One word access; called just after a rising edge with the DUT in IDLE.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int stall = 0, we_low = 0, oe_low = 0, dqoe_hi = 0, first = -1, wd;
        bit done = 1'b0;
        read_en = r; write_en = w; address = a; write_data = d;
        wd = int'((a - BASE) >> 2);
        if (w)      ref_mem[wd] = d;
        else if (r) last_rd = ref_mem[wd];
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
            end else begin
                stall++;
                if (!sram_we_n) we_low++;
                if (!sram_oe_n) oe_low++;
                if (sram_dq_oe) dqoe_hi++;
                if (first < 0 && (!sram_oe_n || sram_dq_oe)) first = c;
                if (c == 1 || c == AC + 1) begin
                    n_vec++;
                    if (sram_addr !== 18'(2 * wd + (c == 1 ? 0 : 1))) begin
                        n_err++;
                        $display("FAIL addr_c%0d: got %0d want %0d", c, sram_addr, 2 * wd + (c == 1 ? 0 : 1));
                    end
                end
            end
        end
        n_vec++;
        if (!done || stall != 2 * AC + 1) begin
            n_err++;
            $display("FAIL stall a=%h: got %0d cycles want %0d (done=%0d)", a, stall, 2 * AC + 1, done);
        end
        n_vec++;
        if (read_data !== last_rd) begin
            n_err++;
            $display("FAIL read_data a=%h: got %h want %h", a, read_data, last_rd);
        end
        n_vec++;
        if (we_low != (w ? 2 * (AC - 1) : 0) || oe_low != (w ? 0 : 2 * AC) ||
            dqoe_hi != (w ? 2 * AC : 0) || first != 1) begin
            n_err++;
            $display("FAIL strobes a=%h w=%0d: we_low=%0d oe_low=%0d dq_oe=%0d first=%0d",
                     a, w, we_low, oe_low, dqoe_hi, first);
        end
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL err a=%h: got %b want 0", a, err);
        end
        if (w) begin
            n_vec++;
            if (sram[2 * wd] !== d[15:0] || sram[2 * wd + 1] !== d[31:16]) begin
                n_err++;
                $display("FAIL sram_content w=%0d: got %h_%h want %h", wd, sram[2 * wd + 1], sram[2 * wd], d);
            end
        end
        @(posedge clk); #1;
        read_en = 1'b0; write_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_vec++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
                n_err++;
                $display("FAIL idle: ready=%b we_n=%b oe_n=%b dq_oe=%b", ready, sram_we_n, sram_oe_n, sram_dq_oe);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; read_en = 1'b0; write_en = 1'b0; address = '0; write_data = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (read_data !== 32'h0 || sram_addr !== 18'h0 || sram_dq_out !== 16'h0 || sram_dq_oe !== 1'b0 ||
            sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || err !== 1'b0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: rd=%h addr=%h dqo=%h oe=%b we_n=%b oe_n=%b err=%b ready=%b",
                     read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n, err, ready);
        end
        rst = 1'b0;
        last_rd = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        idle(2);
        access(1'b1, 1'b0, 32'd1024, 32'h0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        access(1'b0, 1'b1, 32'd1028, 32'h00000001);
        access(1'b1, 1'b0, 32'd1028, 32'h0);
        idle(1);
    endtask

    task automatic test_both();
        access(1'b1, 1'b1, 32'd1032, 32'h12345678);
        idle(1);
        access(1'b1, 1'b0, 32'd1032, 32'h0);
        idle(1);
    endtask

    task automatic test_reset_mid();
        read_en = 1'b0; write_en = 1'b1; address = BASE + 32'd6000; write_data = 32'hA5A5C3C3;
        repeat (AC + 2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || read_data !== 32'h0 || sram_oe_n !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: we_n=%b dq_oe=%b rd=%h oe_n=%b", sram_we_n, sram_dq_oe, read_data, sram_oe_n);
        end
        write_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'h0;
        @(posedge clk); #1;
        idle(2);
    endtask

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    task automatic test_range_err(input logic [31:0] a);
        read_en = 1'b1; write_en = 1'b0; address = a;
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL range_c0 a=%h: ready=%b want 0", a, ready);
        end
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b1 || err !== 1'b1 || sram_oe_n !== 1'b1 || sram_we_n !== 1'b1 ||
            sram_dq_oe !== 1'b0 || read_data !== last_rd) begin
            n_err++;
            $display("FAIL range_c1 a=%h: ready=%b err=%b oe_n=%b we_n=%b dq_oe=%b rd=%h want rd=%h",
                     a, ready, err, sram_oe_n, sram_we_n, sram_dq_oe, read_data, last_rd);
        end
        @(posedge clk); #1;
        read_en = 1'b0;
        @(negedge clk);
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL range_pulse a=%h: err=%b want 0", a, err);
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            int op;
            logic [31:0] a;
            op = int'($urandom_range(0, 3));
            a  = BASE + 32'($urandom_range(0, 63)) * 4;
            case (op)
                0, 3:    access(1'b1, 1'b0, a, $urandom);
                1:       access(1'b0, 1'b1, a, $urandom);
                default: access(1'b1, 1'b1, a, $urandom);
            endcase
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;
        last_rd = 32'h0;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_both();
        test_random(40);
        test_reset_mid();
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        test_range_err(32'd1026);
        test_range_err(32'd1020);
        test_range_err(BASE + (32'd1 << 19));
`endif
        access(1'b1, 1'b0, 32'd1024, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
